// File: rtl/ripple_counter_n.sv
// ripple_counter_n: parametrised up/down counter with a ripple full-adder next-value chain.
//   in_clock       rising-edge clock
//   in_reset       asynchronous active-low reset
//   in_enable      one count step per enabled cycle
//   in_up          1 = increment, 0 = decrement
//   in_load        synchronous load strobe (beats in_enable)
//   in_load_value  load value, clamped to MAX_VALUE
//   in_clear_flag  clears out_overflow (a same-cycle boundary event wins)
//   out_value      registered count, 0..MAX_VALUE
//   out_terminal   combinational: at the range end in the current direction
//   out_wrap       registered one-cycle pulse on each range-boundary event
//   out_overflow   sticky range-boundary flag

module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module ripple_counter_n #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             in_clock,
    input  logic             in_reset,
    input  logic             in_enable,
    input  logic             in_up,
    input  logic             in_load,
    input  logic [WIDTH-1:0] in_load_value,
    input  logic             in_clear_flag,
    output logic [WIDTH-1:0] out_value,
    output logic             out_terminal,
    output logic             out_wrap,
    output logic             out_overflow
);
    logic [WIDTH-1:0] value_q, value_d, addend, sum, load_clamped;
    logic [WIDTH:0]   carry;
    logic             wrap_q, wrap_d, ovf_q, ovf_d, at_end, boundary, co_unused;

    // Decrement is an add of all-ones; the carry out of the top cell is meaningless here.
    assign addend   = in_up ? WIDTH'(1) : '1;
    assign carry[0] = 1'b0;
    assign co_unused = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        fa u_fa (
            .a_i(value_q[i]),
            .b_i(addend[i]),
            .c_i(carry[i]),
            .s_o(sum[i]),
            .c_o(carry[i+1])
        );
    end

    assign at_end       = in_up ? (value_q == MAX_VALUE) : (value_q == '0);
    assign boundary     = !in_load && in_enable && at_end;
    assign load_clamped = (in_load_value > MAX_VALUE) ? MAX_VALUE : in_load_value;

    always_comb begin
        value_d = in_load    ? load_clamped :
                  !in_enable ? value_q      :
                  !at_end    ? sum          :
                  SATURATE   ? value_q      :
                  in_up      ? '0           : MAX_VALUE;
        wrap_d  = boundary;
        ovf_d   = boundary || (ovf_q && !in_clear_flag);
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            value_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_value    = value_q;
    assign out_terminal = at_end;
    assign out_wrap     = wrap_q;
    assign out_overflow = ovf_q;
endmodule

// File: tb/tb_ripple_counter_n.sv
// tb_ripple_counter_n: scoreboard bench driving four counter configurations with shared stimulus.
module tb_ripple_counter_n;
    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, up = 1'b1, ld = 1'b0, clr = 1'b0;
    logic [7:0] lv = '0;
    logic [7:0] v0, v1;
    logic [3:0] v2, v3;
    logic [3:0] term, wrap, ovf;
    logic [31:0] dv [4];
    int n_vec = 0, n_err = 0;

    int unsigned m_max  [4] = '{255, 9, 15, 11};
    int unsigned m_mask [4] = '{255, 255, 15, 15};
    bit          m_sat  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int unsigned m_v    [4];
    bit          m_w    [4];
    bit          m_o    [4];

    typedef struct {
        int unsigned v;
        bit          t;
        bit          w;
        bit          o;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    ripple_counter_n u0 (
        .in_clock(clk), .in_reset(rst_n), .in_enable(en), .in_up(up), .in_load(ld),
        .in_load_value(lv), .in_clear_flag(clr), .out_value(v0),
        .out_terminal(term[0]), .out_wrap(wrap[0]), .out_overflow(ovf[0])
    );
    ripple_counter_n #(.WIDTH(8), .MAX_VALUE(8'd9)) u1 (
        .in_clock(clk), .in_reset(rst_n), .in_enable(en), .in_up(up), .in_load(ld),
        .in_load_value(lv), .in_clear_flag(clr), .out_value(v1),
        .out_terminal(term[1]), .out_wrap(wrap[1]), .out_overflow(ovf[1])
    );
    ripple_counter_n #(.WIDTH(4), .SATURATE(1'b1)) u2 (
        .in_clock(clk), .in_reset(rst_n), .in_enable(en), .in_up(up), .in_load(ld),
        .in_load_value(lv[3:0]), .in_clear_flag(clr), .out_value(v2),
        .out_terminal(term[2]), .out_wrap(wrap[2]), .out_overflow(ovf[2])
    );
    ripple_counter_n #(.WIDTH(4), .MAX_VALUE(4'd11)) u3 (
        .in_clock(clk), .in_reset(rst_n), .in_enable(en), .in_up(up), .in_load(ld),
        .in_load_value(lv[3:0]), .in_clear_flag(clr), .out_value(v3),
        .out_terminal(term[3]), .out_wrap(wrap[3]), .out_overflow(ovf[3])
    );

    assign dv[0] = {24'b0, v0};
    assign dv[1] = {24'b0, v1};
    assign dv[2] = {28'b0, v2};
    assign dv[3] = {28'b0, v3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 4; i++) begin
            m_v[i] = 0;
            m_w[i] = 1'b0;
            m_o[i] = 1'b0;
        end
    endtask

    // Drive one cycle, push each configuration's expected result, then pop and compare after the edge.
    task automatic drive(input bit e, input bit u, input bit l, input logic [7:0] val, input bit c);
        int unsigned lvm;
        bit          ends, bnd;
        exp_t        x;
        en = e; up = u; ld = l; lv = val; clr = c;
        for (int i = 0; i < 4; i++) begin
            lvm  = val & m_mask[i];
            ends = u ? (m_v[i] == m_max[i]) : (m_v[i] == 0);
            bnd  = !l && e && ends;
            if (l)
                m_v[i] = (lvm > m_max[i]) ? m_max[i] : lvm;
            else if (e)
                m_v[i] = !ends ? ((u ? m_v[i] + 1 : m_v[i] - 1) & m_mask[i]) :
                         m_sat[i] ? m_v[i] : (u ? 0 : m_max[i]);
            m_w[i] = bnd;
            m_o[i] = bnd || (m_o[i] && !c);
            x.v = m_v[i];
            x.t = u ? (m_v[i] == m_max[i]) : (m_v[i] == 0);
            x.w = m_w[i];
            x.o = m_o[i];
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            x = sb.pop_front();
            chk($sformatf("u%0d.value", i), dv[i], x.v);
            chk($sformatf("u%0d.terminal", i), 32'(term[i]), 32'(x.t));
            chk($sformatf("u%0d.wrap", i), 32'(wrap[i]), 32'(x.w));
            chk($sformatf("u%0d.overflow", i), 32'(ovf[i]), 32'(x.o));
            chk($sformatf("u%0d.range", i), 32'(dv[i] <= m_max[i]), 32'd1);
        end
    endtask

    initial begin
        reset_model();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset.value", dv[i], 0);
            chk("reset.wrap", 32'(wrap[i]), 0);
            chk("reset.overflow", 32'(ovf[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-count must clear without a clock edge.
        drive(1'b0, 1'b1, 1'b1, 8'h37, 1'b0);
        chk("load37", dv[0], 32'h37);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.value", dv[0], 0);
        chk("async_rst.value_mod", dv[1], 0);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;

        repeat (5) drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("count5.value", dv[0], 5);
        chk("count5.wrap", 32'(wrap[0]), 0);

        drive(1'b0, 1'b1, 1'b1, 8'hFE, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("upwrap.ff", dv[0], 32'hFF);
        chk("upwrap.terminal", 32'(term[0]), 1);
        chk("upwrap.nowrap", 32'(wrap[0]), 0);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("upwrap.zero", dv[0], 0);
        chk("upwrap.wrap", 32'(wrap[0]), 1);
        chk("upwrap.overflow", 32'(ovf[0]), 1);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("upwrap.wrap_off", 32'(wrap[0]), 0);
        chk("upwrap.sticky", 32'(ovf[0]), 1);

        drive(1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("mod.down0", dv[1], 0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("mod.down9", dv[1], 9);
        chk("mod.wrap", 32'(wrap[1]), 1);
        drive(1'b0, 1'b1, 1'b1, 8'd3, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'd200, 1'b0);
        chk("mod.clamp", dv[1], 9);
        chk("mod.clamp_nowrap", 32'(wrap[1]), 0);

        drive(1'b0, 1'b1, 1'b1, 8'd14, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("sat.first", dv[2], 15);
        chk("sat.first_wrap", 32'(wrap[2]), 0);
        repeat (3) begin
            drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
            chk("sat.hold", dv[2], 15);
            chk("sat.wrap", 32'(wrap[2]), 1);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("sat.down", dv[2], 14);
        chk("sat.down_wrap", 32'(wrap[2]), 0);

        drive(1'b1, 1'b1, 1'b1, 8'h10, 1'b0);
        chk("prio.load", dv[0], 32'h10);
        drive(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("clr.wrap_wins", 32'(ovf[0]), 1);
        chk("clr.wrap", 32'(wrap[0]), 1);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("clr.alone", 32'(ovf[0]), 0);

        #2;
        rst_n = 1'b0;
        #1;
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2000)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                  8'($urandom), $urandom_range(0, 19) == 0);

        chk("sb.empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
